// File: rtl/gray_fifo_pkg.sv
// Shared constants and the binary-to-Gray helper for the Gray-pointer FIFO controller.
package gray_fifo_pkg;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_AFULL_LEVEL = 12;
  localparam int GRAY_MAXW       = 32;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_ptr.sv
// Binary pointer with a registered Gray shadow; Gray is computed from the next binary value
// so both registers always describe the same position.
module gray_ptr
  import gray_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] bin_o,
  output logic [W-1:0] gray_o
);
  logic [W-1:0] bin_q, bin_d, gray_q;

  assign bin_d = bin_q + W'(inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= W'(bin2gray(GRAY_MAXW'(bin_d)));
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller for an external async-read RAM with Gray-coded pointers.
// Define GRAY_FIFO_CTRL_ERR_EN to build the sticky write-while-full flag.
module gray_fifo_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int AFULL_LEVEL = DEF_AFULL_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  err_overflow
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_bin, rd_bin;
  logic          push, pop;

  assign push = wr_valid & ~full;
  assign pop  = rd_ready & ~empty;

  gray_ptr #(.W(PW)) u_wr_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (push),
    .bin_o  (wr_bin),
    .gray_o (wr_ptr_gray)
  );

  gray_ptr #(.W(PW)) u_rd_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (pop),
    .bin_o  (rd_bin),
    .gray_o (rd_ptr_gray)
  );

  // Wrap bits distinguish full from empty when the address bits coincide.
  assign empty       = (wr_bin == rd_bin);
  assign full        = (wr_bin[ADDR_WIDTH] != rd_bin[ADDR_WIDTH]) &&
                       (wr_bin[ADDR_WIDTH-1:0] == rd_bin[ADDR_WIDTH-1:0]);
  assign count       = wr_bin - rd_bin;
  assign almost_full = (count >= PW'(AFULL_LEVEL));
  assign wr_ready    = ~full;
  assign rd_valid    = ~empty;
  assign wr_en       = push;
  assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];
  assign rd_addr     = rd_bin[ADDR_WIDTH-1:0];

`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              err_q <= 1'b0;
    else if (wr_valid & full)  err_q <= 1'b1;
  end
  assign err_overflow = err_q;
`else
  assign err_overflow = 1'b0;
`endif
endmodule

// File: doc/gray_fifo_ctrl.md
GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: address width; depth = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter AFULL_LEVEL, default 12: occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_valid  in  1  producer offers a word.
REQ-006 SHALL have port wr_ready  out  1  controller accepts a word (= !full).
REQ-007 SHALL have port rd_valid  out  1  head word available (= !empty).
REQ-008 SHALL have port rd_ready  in  1  consumer takes the head word.
REQ-009 SHALL have port wr_en  out  1  external RAM write strobe (= wr_valid & wr_ready).
REQ-010 SHALL have port wr_addr  out  ADDR_WIDTH  RAM write address (tail).
REQ-011 SHALL have port rd_addr  out  ADDR_WIDTH  RAM read address (head, async-read RAM, first-word-fall-through).
REQ-012 SHALL have port wr_ptr_gray  out  ADDR_WIDTH+1  Gray-coded write pointer incl. wrap bit.
REQ-013 SHALL have port rd_ptr_gray  out  ADDR_WIDTH+1  Gray-coded read pointer incl. wrap bit.
REQ-014 SHALL have port count  out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH.
REQ-015 SHALL have ports full, empty, almost_full  out  1 each  status flags.
REQ-016 SHALL have port err_overflow  out  1  sticky write-while-full flag (see Configuration).

Function
REQ-017 Push SHALL occur on an edge where wr_valid & wr_ready; pop on an edge where rd_valid & rd_ready.
REQ-018 Binary pointers SHALL be ADDR_WIDTH+1 bits; increment mod 2**(ADDR_WIDTH+1); addr = low ADDR_WIDTH bits.
REQ-019 Gray pointers SHALL be registered, = bin ^ (bin >> 1) of the same-cycle binary pointer, changing exactly one bit per increment, including wrap from max to 0.
REQ-020 empty SHALL be (wr_bin == rd_bin); full SHALL be MSBs differ and low bits equal; both decoded from registered pointers only.
REQ-021 count SHALL be wr_bin - rd_bin (mod 2**(ADDR_WIDTH+1)); almost_full = (count >= AFULL_LEVEL).
REQ-022 Latency: push at edge N SHALL make empty=0, rd_valid=1 and count incremented in the cycle after edge N; pop likewise frees full after one edge.
REQ-023 Simultaneous push and pop (neither full nor empty) SHALL advance both pointers and leave count unchanged.
REQ-024 When full, wr_valid SHALL be ignored (no pointer move, wr_en=0); a concurrent pop SHALL proceed.
REQ-025 When empty, rd_ready SHALL be ignored; a concurrent push SHALL proceed; no write-through bypass.
REQ-026 Controller state SHALL be only the two pointers plus the error flag; no FSM beyond pointer logic.

Reset
REQ-027 reset_n low SHALL asynchronously clear both binary and Gray pointers to 0, err_overflow to 0.
REQ-028 Reset outputs: empty=1, full=0, almost_full=0, count=0, wr_ready=1, rd_valid=0, wr_en=0, addresses 0.
REQ-029 Reset mid-operation SHALL discard contents; release SHALL be synchronized externally.

Configuration
REQ-030 Macro GRAY_FIFO_CTRL_ERR_EN defined: err_overflow SHALL set on any edge with wr_valid & full and hold until reset.
REQ-031 Macro undefined: err_overflow SHALL be tied 0, no flop instantiated.

Structure
REQ-032 Shared package gray_fifo_pkg SHALL hold default ADDR_WIDTH/AFULL_LEVEL constants and the bin-to-Gray function.
REQ-033 One sub-module gray_ptr SHALL implement a binary+Gray pointer pair with inc and async active-low reset; instantiated twice.

Verification
REQ-034 Reset asserted mid-traffic -> all outputs per REQ-028 immediately, without a clock edge.
REQ-035 16 pushes, no pops (ADDR_WIDTH=4) -> almost_full after 12th, full/wr_ready=0 and count=16 after 16th, wr_addr back to 0.
REQ-036 17th push while full -> no pointer change; err_overflow=1 with macro, 0 without.
REQ-037 Full FIFO, push and pop same cycle -> only pop; count 15, full=0 next cycle.
REQ-038 40 push/pop pairs at count=3 -> count stays 3; each Gray pointer change has Hamming distance 1, incl. 31->0 wrap.
REQ-039 Drain to empty, then rd_ready=1 with push -> empty deasserts one cycle later, rd_addr unchanged at the pushed slot.
